// File: rtl/bridge_pkg.sv
// Shared types for the AHB-to-APB bridge: FSM state encoding and AHB HTRANS codes.
package bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_RENABLE = 3'd2,
    ST_WWAIT   = 3'd3,
    ST_WRITE   = 3'd4,
    ST_WENABLE = 3'd5
  } bridge_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // NONSEQ and SEQ carry a real transfer; IDLE and BUSY never do.
  function automatic logic is_active_trans(input logic [1:0] trans);
    logic active;
    case (trans)
      HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
      default:                   active = 1'b0;
    endcase
    return active;
  endfunction

endpackage

// File: rtl/bridge_if.sv
// Bundle of the AHB slave-side and APB master-side signals around the bridge.
interface bridge_if;

  logic        hselapb;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] prdata;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic        hresp;
  logic        hready;
  logic [31:0] hrdata;

  // The surrounding system: AHB master plus APB peripheral.
  modport master (
    output hselapb, hwrite, htrans, haddr, hwdata, prdata,
    input  paddr, pwdata, psel, penable, pwrite, hresp, hready, hrdata
  );

  // The bridge itself.
  modport slave (
    input  hselapb, hwrite, htrans, haddr, hwdata, prdata,
    output paddr, pwdata, psel, penable, pwrite, hresp, hready, hrdata
  );

endinterface

// File: rtl/bridge_rtl.sv
// AHB-to-APB bridge: one AHB transfer becomes one APB setup+access pair,
// reads take two cycles after address acceptance and writes three.
module bridge_rtl
  import bridge_pkg::*;
(
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hselapb,
  input  logic        hwrite,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  input  logic [31:0] prdata,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic        hresp,
  output logic        hready,
  output logic [31:0] hrdata
);

  bridge_state_e state_q, state_d;
  logic [31:0]   paddr_q, paddr_d;
  logic [31:0]   pwdata_q, pwdata_d;
  logic          psel_q, psel_d;
  logic          penable_q, penable_d;
  logic          pwrite_q, pwrite_d;
  logic          valid_xfer;

  // hselapb gates first so X on htrans cannot leak through an unselected slot.
  assign valid_xfer = hselapb && is_active_trans(htrans);

  always_ff @(posedge hclk or posedge hresetn) begin
    if (hresetn) begin
      state_q   <= ST_IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
    end
  end

  // APB controls are computed from the next state so the registered
  // outputs line up with the state they belong to.
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    case (state_q)
      ST_IDLE, ST_RENABLE, ST_WENABLE: begin
        if (valid_xfer) begin
          paddr_d = haddr;
          state_d = hwrite ? ST_WWAIT : ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ:  state_d = ST_RENABLE;
      ST_WWAIT: begin
        pwdata_d = hwdata;
        state_d  = ST_WRITE;
      end
      ST_WRITE: state_d = ST_WENABLE;
      default:  state_d = ST_IDLE;
    endcase
    psel_d    = (state_d inside {ST_READ, ST_RENABLE, ST_WRITE, ST_WENABLE});
    penable_d = (state_d inside {ST_RENABLE, ST_WENABLE});
    pwrite_d  = (state_d inside {ST_WWAIT, ST_WRITE, ST_WENABLE});
  end

  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign hready  = (state_q inside {ST_IDLE, ST_RENABLE, ST_WENABLE});
  assign hresp   = 1'b0;
  assign hrdata  = prdata;

endmodule

// File: tb/tb_bridge_rtl.sv
// Scoreboard bench for bridge_rtl: a driver issues AHB transfers and queues the
// APB transfer each should produce; a monitor checks every APB cycle it sees.
module tb_bridge_rtl;
  import bridge_pkg::*;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
    int          done_edge;
  } apb_exp_t;

  logic hclk = 1'b0;
  logic hresetn;
  int   n_edges  = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic saw_setup = 1'b0;

  apb_exp_t    exp_q[$];
  apb_exp_t    mon_e;
  logic [31:0] mem_ref [logic [31:0]];
  logic [31:0] mem_slv [logic [31:0]];

  bridge_if bus();

  bridge_rtl dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .hselapb (bus.hselapb),
    .hwrite  (bus.hwrite),
    .htrans  (bus.htrans),
    .haddr   (bus.haddr),
    .hwdata  (bus.hwdata),
    .prdata  (bus.prdata),
    .paddr   (bus.paddr),
    .pwdata  (bus.pwdata),
    .psel    (bus.psel),
    .penable (bus.penable),
    .pwrite  (bus.pwrite),
    .hresp   (bus.hresp),
    .hready  (bus.hready),
    .hrdata  (bus.hrdata)
  );

  always #5 hclk = ~hclk;

  always @(posedge hclk) n_edges <= n_edges + 1;

  // Contents of a location nobody has written yet.
  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return mem_ref.exists(a) ? mem_ref[a] : init_val(a);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // APB peripheral: stores completed writes, presents read data for the current paddr.
  always @(negedge hclk) begin
    if (!hresetn && bus.psel && bus.penable && bus.pwrite) mem_slv[bus.paddr] = bus.pwdata;
  end

  always @(posedge hclk) begin
    #1;
    bus.prdata = mem_slv.exists(bus.paddr) ? mem_slv[bus.paddr] : init_val(bus.paddr);
  end

  // Monitor: every APB cycle must match the oldest outstanding expectation.
  always @(negedge hclk) begin
    if (hresetn) begin
      saw_setup = 1'b0;
    end else if (bus.psel) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_psel", 32'(bus.psel), 32'd0);
      end else begin
        mon_e = exp_q[0];
        checkOutput("paddr", bus.paddr, mon_e.addr);
        checkOutput("pwrite", 32'(bus.pwrite), 32'(mon_e.write));
        if (mon_e.write) checkOutput("pwdata", bus.pwdata, mon_e.data);
        if (!bus.penable) begin
          checkOutput("hready_setup", 32'(bus.hready), 32'd0);
          saw_setup = 1'b1;
        end else begin
          checkOutput("setup_before_access", 32'(saw_setup), 32'd1);
          checkOutput("hready_access", 32'(bus.hready), 32'd1);
          checkOutput("hresp", 32'(bus.hresp), 32'd0);
          checkOutput("latency", 32'(n_edges + 1), 32'(mon_e.done_edge));
          if (!mon_e.write) checkOutput("hrdata", bus.hrdata, mon_e.data);
          void'(exp_q.pop_front());
          saw_setup = 1'b0;
        end
      end
    end
  end

  // Called just after a rising edge: drives one AHB address phase, holds it
  // until hready, then drives the matching write data for the data phase.
  task automatic applyStimulus(input logic sel, input logic write, input logic [1:0] trans,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output int acc_edge);
    int       waited = 0;
    logic     valid;
    apb_exp_t e;
    valid = sel && (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ);
    bus.hselapb = sel;
    bus.hwrite  = write;
    bus.htrans  = trans;
    bus.haddr   = addr;
    @(negedge hclk);
    while (!bus.hready && waited < 20) begin
      @(negedge hclk);
      waited++;
    end
    if (!bus.hready) checkOutput("hready_timeout", 32'(bus.hready), 32'd1);
    acc_edge = n_edges;
    if (valid === 1'b1) begin
      e.write     = write;
      e.addr      = addr;
      e.done_edge = n_edges + 1 + (write ? 3 : 2);
      if (write) begin
        e.data        = wdata;
        mem_ref[addr] = wdata;
      end else begin
        e.data = ref_read(addr);
      end
      exp_q.push_back(e);
    end else if (exp_q.size() == 0 && !bus.penable) begin
      checkOutput("ignored_psel", 32'(bus.psel), 32'd0);
    end
    @(posedge hclk);
    #1;
    bus.hwdata = wdata;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_psel"}, 32'(bus.psel), 32'd0);
    checkOutput({tag, "_penable"}, 32'(bus.penable), 32'd0);
    checkOutput({tag, "_pwrite"}, 32'(bus.pwrite), 32'd0);
    checkOutput({tag, "_paddr"}, bus.paddr, 32'd0);
    checkOutput({tag, "_pwdata"}, bus.pwdata, 32'd0);
    checkOutput({tag, "_hready"}, 32'(bus.hready), 32'd1);
    checkOutput({tag, "_hresp"}, 32'(bus.hresp), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got %0d edges, expected completion", n_edges);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          a0, ra, wa, waited;
    logic        r_sel, r_wr;
    logic [1:0]  r_tr;
    logic [31:0] r_addr, r_data;

    bus.hselapb = 1'b0;
    bus.hwrite  = 1'b0;
    bus.htrans  = HTRANS_IDLE;
    bus.haddr   = '0;
    bus.hwdata  = '0;
    hresetn     = 1'b1;
    #1;
    checkResetOutputs("por");
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b0;
    @(posedge hclk);
    #1;

    // Single read of 40 from address 32, then single write of 0xDEADBEEF to 0x100.
    mem_ref[32'd32] = 32'd40;
    mem_slv[32'd32] = 32'd40;
    applyStimulus(1'b1, 1'b0, HTRANS_NONSEQ, 32'd32, 32'd0, a0);
    applyStimulus(1'b1, 1'b1, HTRANS_NONSEQ, 32'h100, 32'hDEADBEEF, a0);
    repeat (3) applyStimulus(1'b0, 1'b0, HTRANS_IDLE, 32'd0, 32'd0, a0);

    // Asynchronous reset pulse between edges while paddr/pwdata hold data.
    #2;
    hresetn = 1'b1;
    #1;
    checkResetOutputs("pulse");
    #1;
    hresetn = 1'b0;
    @(posedge hclk);
    #1;

    // Ignored slots: IDLE, BUSY, deselected with valid htrans, deselected with X.
    applyStimulus(1'b1, 1'b0, HTRANS_IDLE, 32'h40, 32'd0, a0);
    applyStimulus(1'b1, 1'b1, HTRANS_BUSY, 32'h44, 32'd0, a0);
    applyStimulus(1'b0, 1'b0, HTRANS_NONSEQ, 32'h48, 32'd0, a0);
    applyStimulus(1'b0, 1'b1, HTRANS_SEQ, 32'h4C, 32'd0, a0);
    applyStimulus(1'b0, 1'bx, 2'bxx, 32'hxxxxxxxx, 32'd0, a0);

    // Back-to-back: the write is accepted in RENABLE with no IDLE in between.
    applyStimulus(1'b1, 1'b0, HTRANS_NONSEQ, 32'h20, 32'd0, ra);
    applyStimulus(1'b1, 1'b1, HTRANS_SEQ, 32'h24, 32'hCAFEF00D, wa);
    checkOutput("b2b_accept_edge", 32'(wa), 32'(ra + 2));
    applyStimulus(1'b1, 1'b0, HTRANS_SEQ, 32'h24, 32'd0, a0);

    for (int i = 0; i < 200; i++) begin
      r_sel  = ($urandom_range(0, 7) != 0);
      r_wr   = 1'($urandom_range(0, 1));
      r_tr   = ($urandom_range(0, 3) != 0) ? {1'b1, 1'($urandom_range(0, 1))}
                                           : {1'b0, 1'($urandom_range(0, 1))};
      r_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      r_data = $urandom;
      if (!r_sel && $urandom_range(0, 1) == 1)
        applyStimulus(1'b0, 1'bx, 2'bxx, 32'hxxxxxxxx, r_data, a0);
      else
        applyStimulus(r_sel, r_wr, r_tr, r_addr, r_data, a0);
    end
    repeat (4) applyStimulus(1'b0, 1'b0, HTRANS_IDLE, 32'd0, 32'd0, a0);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset asserted during the WRITE setup phase must kill the transfer.
    applyStimulus(1'b1, 1'b1, HTRANS_NONSEQ, 32'h300, 32'h12345678, a0);
    bus.hselapb = 1'b0;
    bus.htrans  = HTRANS_IDLE;
    waited = 0;
    @(negedge hclk);
    while (!(bus.psel && !bus.penable && bus.pwrite) && waited < 6) begin
      @(negedge hclk);
      waited++;
    end
    checkOutput("reached_write_setup", 32'(bus.psel && !bus.penable && bus.pwrite), 32'd1);
    #2;
    hresetn = 1'b1;
    #1;
    checkResetOutputs("abort");
    exp_q.delete();
    @(negedge hclk);
    hresetn = 1'b0;
    repeat (3) @(negedge hclk);
    checkOutput("abort_no_psel", 32'(bus.psel), 32'd0);
    checkOutput("abort_no_write", 32'(mem_slv.exists(32'h300)), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bridge_rtl.md
BRIDGE_RTL -- requirements
Module: bridge_rtl

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-high reset; the clock port is hclk and the reset port is hresetn (name kept despite active-high polarity).
REQ-002 The ports SHALL be, in this positional order:
- hclk  in  1  AHB/APB clock
- hresetn  in  1  async reset, active-high
- hselapb  in  1  AHB slave select for the APB region
- hwrite  in  1  AHB transfer direction, 1=write
- htrans  in  2  AHB transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- haddr  in  32  AHB address
- hwdata  in  32  AHB write data, in the data phase
- prdata  in  32  APB read data
- paddr  out  32  APB address
- pwdata  out  32  APB write data
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- hresp  out  1  AHB response
- hready  out  1  AHB ready
- hrdata  out  32  AHB read data
REQ-003 There SHALL be no parameters; all widths are fixed as listed.

Function
REQ-004 A valid transfer SHALL be hselapb=1 AND htrans in {10, 11}, sampled only on a rising hclk edge when hready=1; IDLE/BUSY or hselapb=0 SHALL be ignored.
REQ-005 The FSM SHALL have the states IDLE, READ, RENABLE, WWAIT, WRITE and WENABLE.
REQ-006 IDLE: hready=1, psel=0, penable=0; on a valid read go to READ and latch haddr; on a valid write go to WWAIT and latch haddr; otherwise stay in IDLE.
REQ-007 READ (APB setup): psel=1, penable=0, pwrite=0, paddr=latched address, hready=0; next state is always RENABLE.
REQ-008 RENABLE (APB access): psel=1, penable=1, pwrite=0, hready=1; the next state SHALL be decided as in IDLE (back-to-back transfers allowed).
REQ-009 WWAIT: hready=0, psel=0; capture hwdata into the write-data register; next state is always WRITE.
REQ-010 WRITE (APB setup): psel=1, penable=0, pwrite=1, paddr=latched address, pwdata=captured data, hready=0; next state is always WENABLE.
REQ-011 WENABLE: psel=1, penable=1, pwrite=1, hready=1; the next state SHALL be decided as in IDLE.
REQ-012 APB outputs (paddr, pwdata, psel, penable, pwrite) SHALL be registered, and paddr/pwdata/pwrite SHALL remain stable through setup and access.
REQ-013 hready SHALL be decoded from the current state.
REQ-014 hrdata SHALL equal prdata combinationally at all times; the master samples it at the end of RENABLE.
REQ-015 hresp SHALL be constant 0 (OKAY); the bridge never signals errors or inserts APB wait states.
REQ-016 Latency: a read SHALL complete 2 cycles after address acceptance; a write SHALL complete 3 cycles after address acceptance.
REQ-017 X on hwrite, htrans or haddr SHALL have no effect while hselapb=0 or while hready=0.

Reset
REQ-018 While hresetn=1 the module SHALL asynchronously force: state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, hready=1, hresp=0.
REQ-019 Reset asserted mid-transfer SHALL abort the transfer with no further APB activity; operation resumes on the first rising edge after hresetn falls.

Structure
REQ-020 A shared package bridge_pkg SHALL hold the state enumeration and the HTRANS codes (IDLE, BUSY, NONSEQ, SEQ).
REQ-021 The design SHALL be a single module with no sub-module; the FSM, address/data registers and output decode are in one file.

Verification
REQ-022 Reset: pulse hresetn high between clock edges -> all outputs immediately at reset values; hready=1, psel=0.
REQ-023 Single read: hselapb=1, htrans=10, hwrite=0, haddr=32, then prdata=40 -> next cycle psel=1, penable=0, paddr=32; following cycle penable=1, hready=1, hrdata=40; then IDLE.
REQ-024 Single write: haddr=0x100 with hwrite=1, htrans=10, then hwdata=0xDEADBEEF -> WWAIT, then psel=1, pwrite=1, paddr=0x100, pwdata=0xDEADBEEF, then penable=1, hready=1.
REQ-025 Back-to-back: a read to 0x20 followed in RENABLE by a SEQ write to 0x24 -> RENABLE goes directly to WWAIT; both APB transfers are correct with no IDLE cycle between them.
REQ-026 Ignored transfers: htrans=00 or 01, or hselapb=0 with valid htrans -> psel stays 0 and hready stays 1.
REQ-027 Mid-transfer reset: assert hresetn during WRITE -> psel=0, penable=0 at once; no WENABLE phase occurs.
